// File: rtl/hxdp_load_ctrl.sv
// Program-load sequencer for the hXDP core: gates imem writes to the halted state,
// sequences datapath reset/start around loads and drains packets before halting.
module hxdp_load_ctrl #(
    parameter int ADDR_WIDTH    = 8,
    parameter int CNT_WIDTH     = 16,
    parameter int RESET_CYCLES  = 16,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_halt,
    input  logic                  cmd_run,
    input  logic                  err_clear,
    input  logic                  pkt_in_flight,
    input  logic                  we_INSTR_in,
    input  logic [ADDR_WIDTH-1:0] imem_addr_in,
    input  logic [255:0]          imem_data_in,
    output logic                  we_INSTR_out,
    output logic [ADDR_WIDTH-1:0] imem_addr_out,
    output logic [255:0]          imem_data_out,
    output logic                  datapath_reset,
    output logic                  start_SPH,
    output logic [1:0]            state,
    output logic [CNT_WIDTH-1:0]  load_count,
    output logic [ADDR_WIDTH-1:0] max_addr,
    output logic                  err_blocked,
    output logic                  err_timeout,
    output logic                  err_empty
);

    typedef enum logic [1:0] {
        ST_HALTED  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    localparam int MAX_CYC = (RESET_CYCLES > DRAIN_TIMEOUT) ? RESET_CYCLES : DRAIN_TIMEOUT;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam logic [TMR_W-1:0] RST_LAST   = TMR_W'(RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [255:0]          data_q, data_d;
    logic [CNT_WIDTH-1:0]  load_q, load_d;
    logic [ADDR_WIDTH-1:0] max_q, max_d;
    logic                  err_blocked_q, err_blocked_d;
    logic                  err_timeout_q, err_timeout_d;
    logic                  err_empty_q, err_empty_d;

    logic accept, enter_halted, set_empty, set_timeout;

    // NOTE: every signal gets a default before the case so no path can leave one unassigned
    // and infer a latch.
    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        enter_halted = 1'b0;
        set_empty    = 1'b0;
        set_timeout  = 1'b0;
        unique case (state_q)
            ST_HALTED: begin
                if (cmd_run) begin
                    if (load_q != '0) begin
                        state_d = ST_RELEASE;
                        tmr_d   = '0;
                    end else begin
                        set_empty = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                tmr_d = tmr_q + 1'b1;
                if (cmd_halt) begin
                    state_d      = ST_HALTED;
                    enter_halted = 1'b1;
                end else if (tmr_q == RST_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cmd_halt) begin
                    state_d = ST_DRAIN;
                    tmr_d   = '0;
                end
            end
            ST_DRAIN: begin
                tmr_d = tmr_q + 1'b1;
                // An empty pipeline wins over a coincident timeout: that is a clean drain.
                if (!pkt_in_flight) begin
                    state_d      = ST_HALTED;
                    enter_halted = 1'b1;
                end else if (tmr_q == DRAIN_LAST) begin
                    state_d      = ST_HALTED;
                    enter_halted = 1'b1;
                    set_timeout  = 1'b1;
                end
            end
            default: state_d = ST_HALTED;
        endcase
    end

    // Write gating uses the current state, so a write alongside cmd_run still lands.
    always_comb begin
        accept = (state_q == ST_HALTED) && we_INSTR_in;
        we_d   = accept;
        addr_d = accept ? imem_addr_in : addr_q;
        data_d = accept ? imem_data_in : data_q;

        load_d = load_q;
        max_d  = max_q;
        if (enter_halted) begin
            load_d = '0;
            max_d  = '0;
        end else if (accept) begin
            if (load_q != '1) load_d = load_q + 1'b1;
            if (imem_addr_in > max_q) max_d = imem_addr_in;
        end

        err_blocked_d = (we_INSTR_in && (state_q != ST_HALTED)) || (err_blocked_q && !err_clear);
        err_timeout_d = set_timeout || (err_timeout_q && !err_clear);
        err_empty_d   = set_empty   || (err_empty_q   && !err_clear);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_HALTED;
            tmr_q         <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            load_q        <= '0;
            max_q         <= '0;
            err_blocked_q <= 1'b0;
            err_timeout_q <= 1'b0;
            err_empty_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            load_q        <= load_d;
            max_q         <= max_d;
            err_blocked_q <= err_blocked_d;
            err_timeout_q <= err_timeout_d;
            err_empty_q   <= err_empty_d;
        end
    end

    assign we_INSTR_out   = we_q;
    assign imem_addr_out  = addr_q;
    assign imem_data_out  = data_q;
    assign datapath_reset = (state_q == ST_HALTED);
    assign start_SPH      = (state_q == ST_RUN);
    assign state          = state_q;
    assign load_count     = load_q;
    assign max_addr       = max_q;
    assign err_blocked    = err_blocked_q;
    assign err_timeout    = err_timeout_q;
    assign err_empty      = err_empty_q;

endmodule

// File: tb/tb_hxdp_load_ctrl.sv
// Directed plus randomized bench for hxdp_load_ctrl, checked every cycle against
// a phase/elapsed-time model with a queue of accepted write addresses.
module tb_hxdp_load_ctrl;

    localparam int AW    = 8;
    localparam int CW    = 16;
    localparam int RCYC  = 16;
    localparam int DTO   = 1024;
    localparam int P_HALTED  = 0;
    localparam int P_RELEASE = 1;
    localparam int P_RUN     = 2;
    localparam int P_DRAIN   = 3;

    logic          clk, rst;
    logic          cmd_halt, cmd_run, err_clear, pkt_in_flight;
    logic          we_INSTR_in;
    logic [AW-1:0] imem_addr_in;
    logic [255:0]  imem_data_in;
    logic          we_INSTR_out;
    logic [AW-1:0] imem_addr_out;
    logic [255:0]  imem_data_out;
    logic          datapath_reset, start_SPH;
    logic [1:0]    state;
    logic [CW-1:0] load_count;
    logic [AW-1:0] max_addr;
    logic          err_blocked, err_timeout, err_empty;

    hxdp_load_ctrl #(
        .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .RESET_CYCLES(RCYC), .DRAIN_TIMEOUT(DTO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_halt(cmd_halt), .cmd_run(cmd_run), .err_clear(err_clear),
        .pkt_in_flight(pkt_in_flight),
        .we_INSTR_in(we_INSTR_in), .imem_addr_in(imem_addr_in), .imem_data_in(imem_data_in),
        .we_INSTR_out(we_INSTR_out), .imem_addr_out(imem_addr_out), .imem_data_out(imem_data_out),
        .datapath_reset(datapath_reset), .start_SPH(start_SPH), .state(state),
        .load_count(load_count), .max_addr(max_addr),
        .err_blocked(err_blocked), .err_timeout(err_timeout), .err_empty(err_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: current phase, the cycle it was entered, and accepted addresses.
    int           m_phase;
    int           m_cyc;
    int           m_start;
    int           m_addrs[$];
    bit           m_we;
    int           m_addr;
    logic [255:0] m_data;
    bit           m_eb, m_et, m_ee;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_load();
        return (m_addrs.size() > 65535) ? 65535 : m_addrs.size();
    endfunction

    function automatic int m_max();
        int mx = 0;
        foreach (m_addrs[i]) if (m_addrs[i] > mx) mx = m_addrs[i];
        return mx;
    endfunction

    task automatic model_reset();
        m_phase = P_HALTED; m_cyc = 0; m_start = 0;
        m_addrs.delete();
        m_we = 0; m_addr = 0; m_data = '0;
        m_eb = 0; m_et = 0; m_ee = 0;
    endtask

    task automatic model_step();
        int  nxt;
        bit  to_halt, set_e, set_t, set_b, acc;
        m_cyc++;
        nxt = m_phase; to_halt = 0; set_e = 0; set_t = 0;
        acc   = (m_phase == P_HALTED) && we_INSTR_in;
        set_b = we_INSTR_in && (m_phase != P_HALTED);
        case (m_phase)
            P_HALTED:  if (cmd_run) begin
                           if (m_load() != 0) begin nxt = P_RELEASE; m_start = m_cyc; end
                           else set_e = 1;
                       end
            P_RELEASE: if (cmd_halt) to_halt = 1;
                       else if (m_cyc - m_start == RCYC) nxt = P_RUN;
            P_RUN:     if (cmd_halt) begin nxt = P_DRAIN; m_start = m_cyc; end
            default:   if (!pkt_in_flight) to_halt = 1;
                       else if (m_cyc - m_start == DTO) begin to_halt = 1; set_t = 1; end
        endcase
        if (to_halt) begin nxt = P_HALTED; m_addrs.delete(); end
        m_we = acc;
        if (acc) begin
            m_addrs.push_back(int'(imem_addr_in));
            m_addr = int'(imem_addr_in);
            m_data = imem_data_in;
        end
        m_eb = set_b | (m_eb & ~err_clear);
        m_et = set_t | (m_et & ~err_clear);
        m_ee = set_e | (m_ee & ~err_clear);
        m_phase = nxt;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".state"}, 256'(state), 256'(m_phase));
        check({tag, ".dp_reset"}, 256'(datapath_reset), 256'(m_phase == P_HALTED));
        check({tag, ".start"}, 256'(start_SPH), 256'(m_phase == P_RUN));
        check({tag, ".we"}, 256'(we_INSTR_out), 256'(m_we));
        check({tag, ".addr"}, 256'(imem_addr_out), 256'(m_addr));
        check({tag, ".data"}, imem_data_out, m_data);
        check({tag, ".load"}, 256'(load_count), 256'(m_load()));
        check({tag, ".max"}, 256'(max_addr), 256'(m_max()));
        check({tag, ".eb"}, 256'(err_blocked), 256'(m_eb));
        check({tag, ".et"}, 256'(err_timeout), 256'(m_et));
        check({tag, ".ee"}, 256'(err_empty), 256'(m_ee));
    endtask

    task automatic tick(input string tag = "cyc");
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic clear_inputs();
        cmd_halt = 0; cmd_run = 0; err_clear = 0; we_INSTR_in = 0;
    endtask

    task automatic do_reset();
        rst = 1; clear_inputs(); pkt_in_flight = 0;
        imem_addr_in = '0; imem_data_in = '0;
        @(negedge clk); @(negedge clk);
        model_reset();
        compare_all("reset");
        rst = 0;
    endtask

    task automatic do_write(input int a, input logic [255:0] d);
        we_INSTR_in = 1; imem_addr_in = AW'(a); imem_data_in = d;
        tick("wr");
        we_INSTR_in = 0;
    endtask

    task automatic pulse_run();
        cmd_run = 1; tick("run"); cmd_run = 0;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        do_reset();

        // Load three lines, then release and run the core.
        do_write(5, {8{32'hAAAA_0005}});
        check("wr5_we", 256'(we_INSTR_out), 256'(1));
        check("wr5_addr", 256'(imem_addr_out), 256'(5));
        do_write(2, {8{32'hBBBB_0002}});
        check("wr2_data", imem_data_out, {8{32'hBBBB_0002}});
        do_write(9, {8{32'hCCCC_0009}});
        tick("idle");
        check("hold_we", 256'(we_INSTR_out), 256'(0));
        check("hold_addr", 256'(imem_addr_out), 256'(9));
        check("load3", 256'(load_count), 256'(3));
        check("max9", 256'(max_addr), 256'(9));
        pulse_run();
        check("rel_state", 256'(state), 256'(1));
        check("rel_dprst", 256'(datapath_reset), 256'(0));
        repeat (RCYC - 1) tick("rel");
        check("rel_last", 256'(state), 256'(1));
        tick("run");
        check("run_state", 256'(state), 256'(2));
        check("run_start", 256'(start_SPH), 256'(1));

        // Writes while running are dropped and flagged; set beats clear.
        do_write(4, {8{32'hDEAD_0004}});
        check("blk_we", 256'(we_INSTR_out), 256'(0));
        check("blk_err", 256'(err_blocked), 256'(1));
        err_clear = 1; tick("clr"); err_clear = 0;
        check("blk_clr", 256'(err_blocked), 256'(0));
        err_clear = 1; we_INSTR_in = 1; tick("setclr"); clear_inputs();
        check("blk_setwins", 256'(err_blocked), 256'(1));

        // Drain with packets retiring after ten cycles.
        pkt_in_flight = 1; cmd_halt = 1; tick("halt"); cmd_halt = 0;
        check("drain_state", 256'(state), 256'(3));
        check("drain_start", 256'(start_SPH), 256'(0));
        repeat (9) tick("drain");
        pkt_in_flight = 0; tick("drained");
        check("drn_state", 256'(state), 256'(0));
        check("drn_dprst", 256'(datapath_reset), 256'(1));
        check("drn_load", 256'(load_count), 256'(0));
        check("drn_to", 256'(err_timeout), 256'(0));

        // Drain that never empties: forced halt on timeout.
        do_write(7, {8{32'h7777_0007}});
        pulse_run();
        repeat (RCYC) tick("rel2");
        pkt_in_flight = 1; cmd_halt = 1; tick("halt2"); cmd_halt = 0;
        repeat (DTO - 1) tick("tmo");
        check("tmo_last", 256'(state), 256'(3));
        tick("tmo_hit");
        check("tmo_state", 256'(state), 256'(0));
        check("tmo_err", 256'(err_timeout), 256'(1));
        pkt_in_flight = 0;

        // Run with nothing loaded, then halt+run together in RELEASE.
        do_reset();
        pulse_run();
        check("empty_state", 256'(state), 256'(0));
        check("empty_err", 256'(err_empty), 256'(1));
        do_write(1, {8{32'h1111_0001}});
        pulse_run();
        check("rel3_state", 256'(state), 256'(1));
        cmd_halt = 1; cmd_run = 1; tick("both"); clear_inputs();
        check("both_state", 256'(state), 256'(0));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cmd_halt      = ($urandom_range(0, 99) < 4);
            cmd_run       = ($urandom_range(0, 99) < 8);
            err_clear     = ($urandom_range(0, 99) < 5);
            pkt_in_flight = ($urandom_range(0, 99) < 85);
            we_INSTR_in   = ($urandom_range(0, 99) < 40);
            imem_addr_in  = AW'($urandom);
            imem_data_in  = rand256();
            tick("rnd");
        end
        clear_inputs(); pkt_in_flight = 0;

        // Asynchronous reset in the middle of RUN.
        do_reset();
        do_write(200, {8{32'h2222_00C8}});
        pulse_run();
        repeat (RCYC) tick("rel4");
        check("arst_pre", 256'(state), 256'(2));
        #2 rst = 1;
        #1;
        check("arst_dprst", 256'(datapath_reset), 256'(1));
        check("arst_start", 256'(start_SPH), 256'(0));
        check("arst_state", 256'(state), 256'(0));
        check("arst_load", 256'(load_count), 256'(0));
        check("arst_max", 256'(max_addr), 256'(0));
        check("arst_we", 256'(we_INSTR_out), 256'(0));
        model_reset();
        @(negedge clk);
        rst = 0;
        compare_all("arst");
        tick("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
